mux21_checker: RTL and testbench



---
 rtl/mux21_checker.sv | 145 ++++++++++++++
 tb/tb_mux21_checker.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux21_checker.sv
// mux21_checker: consumer of the Fredkin-gate 2:1 MUX stage.
// Checks each accepted transaction against Fredkin semantics, queues the
// selected bit with a pass/fail tag in a DEPTH-entry FIFO and keeps
// saturating pass/error counters plus a sticky error flag.
// Build option: define MUX21_RECOVER_EN to also store the inputs recovered
// by the Fredkin inverse and present them on out_rec (otherwise out_rec = 0).

module mux21_checker #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel,
    input  logic             ip_1,
    input  logic             ip_2,
    input  logic             mux_out,
    input  logic             garbage_1,
    input  logic             garbage_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_data,
    output logic             out_err,
    output logic [2:0]       out_rec,
    input  logic             clr,
    output logic             err_flag,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int AW = $clog2(DEPTH);

    // Entry layout: [0] err tag, [1] mux_out, [4:2] recovered {sel, ip_1, ip_2}
`ifdef MUX21_RECOVER_EN
    localparam int EW = 5;
`else
    localparam int EW = 2;
`endif

    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          exp_q;
    logic          exp_r;
    logic          exp_p;
    logic          err;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] head;

    // Fredkin forward check: expected outputs from the applied inputs
    always_comb begin
        exp_q = sel ? ip_2 : ip_1;
        exp_r = sel ? ip_1 : ip_2;
        exp_p = sel;
        err   = (mux_out != exp_q) | (garbage_1 != exp_r) | (garbage_2 != exp_p);
    end

    // Entry to push; recovered inputs come from the Fredkin inverse of the outputs
    always_comb begin
        wr_entry    = '0;
        wr_entry[0] = err;
        wr_entry[1] = mux_out;
`ifdef MUX21_RECOVER_EN
        wr_entry[4] = garbage_2;
        wr_entry[3] = garbage_2 ? garbage_1 : mux_out;
        wr_entry[2] = garbage_2 ? mux_out : garbage_1;
`endif
    end

    // FIFO status and handshakes; in_ready depends on pointer state only
    always_comb begin
        empty    = (wr_ptr == rd_ptr);
        full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        in_ready = !full;
        push     = in_valid && !full;
        pop      = out_ready && !empty;
    end

    // FIFO storage; stale contents are never visible because outputs are gated by empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_entry;
        end
    end

    // Read/write pointers with an extra wrap bit to distinguish full from empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

    // Saturating statistics and sticky flag; clr wins over a same-cycle accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else if (clr) begin
            pass_cnt <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else if (push) begin
            if (err) begin
                err_flag <= 1'b1;
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end
            end else if (pass_cnt != '1) begin
                pass_cnt <= pass_cnt + CNT_W'(1);
            end
        end
    end

    // Head-of-queue outputs, forced to zero while the FIFO is empty
    always_comb begin
        head      = mem[rd_ptr[AW-1:0]];
        out_valid = !empty;
        out_data  = 1'b0;
        out_err   = 1'b0;
        out_rec   = 3'b000;
        if (!empty) begin
            out_data = head[1];
            out_err  = head[0];
`ifdef MUX21_RECOVER_EN
            out_rec  = head[4:2];
`endif
        end
    end

endmodule

// File: tb/tb_mux21_checker.sv
// Self-checking bench for mux21_checker: table-driven vectors, directed
// multi-cycle sequences and randomized traffic against a queue-based model.
// A second instance with CNT_W=3 shares all inputs to exercise saturation.

module tb_mux21_checker;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       sel;
    logic       ip_1;
    logic       ip_2;
    logic       mux_out;
    logic       garbage_1;
    logic       garbage_2;
    logic       out_valid;
    logic       out_ready;
    logic       out_data;
    logic       out_err;
    logic [2:0] out_rec;
    logic       clr;
    logic       err_flag;
    logic [15:0] pass_cnt;
    logic [15:0] err_cnt;

    logic       s_in_ready;
    logic       s_out_valid;
    logic       s_out_data;
    logic       s_out_err;
    logic [2:0] s_out_rec;
    logic       s_err_flag;
    logic [2:0] s_pass_cnt;
    logic [2:0] s_err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux21_checker #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .ip_1(ip_1), .ip_2(ip_2),
        .mux_out(mux_out), .garbage_1(garbage_1), .garbage_2(garbage_2),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .out_rec(out_rec), .clr(clr), .err_flag(err_flag),
        .pass_cnt(pass_cnt), .err_cnt(err_cnt)
    );

    mux21_checker #(.DEPTH(DEPTH), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .sel(sel), .ip_1(ip_1), .ip_2(ip_2),
        .mux_out(mux_out), .garbage_1(garbage_1), .garbage_2(garbage_2),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_err(s_out_err), .out_rec(s_out_rec), .clr(clr), .err_flag(s_err_flag),
        .pass_cnt(s_pass_cnt), .err_cnt(s_err_cnt)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic       data;
        logic       err;
        logic [2:0] rec;
    } ent_t;

    ent_t q[$];
    int   pass_n = 0;
    int   err_n  = 0;
    logic flag_m = 1'b0;

    // Fredkin gate {c, a, b} -> {c, c?b:a, c?a:b}; it is its own inverse
    function automatic logic [2:0] fredkin(input logic c, input logic a, input logic b);
        return {c, c ? b : a, c ? a : b};
    endfunction

    function automatic int sat(input int v, input int w);
        int m;
        m = (1 << w) - 1;
        return (v > m) ? m : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_tx(input logic v, input logic s, input logic a, input logic b,
                            input logic [2:0] flip);
        logic [2:0] o;
        o         = fredkin(s, a, b) ^ flip;
        in_valid  = v;
        sel       = s;
        ip_1      = a;
        ip_2      = b;
        garbage_2 = o[2];
        mux_out   = o[1];
        garbage_1 = o[0];
    endtask

    task automatic drive_legal_random();
        drive_tx(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 3'b000);
    endtask

    // One clock: compare head/status with the model, clock, then update model
    task automatic cycle();
        int   occ;
        logic acc;
        logic pp;
        logic c;
        ent_t e;
        occ = q.size();
        chk("in_ready", in_ready, occ < DEPTH);
        chk("out_valid", out_valid, occ != 0);
        chk("s_in_ready", s_in_ready, occ < DEPTH);
        chk("s_out_valid", s_out_valid, occ != 0);
        if (occ != 0) begin
            chk("out_data", out_data, q[0].data);
            chk("out_err", out_err, q[0].err);
            chk("out_rec", out_rec, q[0].rec);
            chk("s_out_data", s_out_data, q[0].data);
            chk("s_out_err", s_out_err, q[0].err);
            chk("s_out_rec", s_out_rec, q[0].rec);
        end else begin
            chk("out_data_empty", out_data, 0);
            chk("out_err_empty", out_err, 0);
            chk("out_rec_empty", out_rec, 0);
        end
        acc    = in_valid && (occ < DEPTH);
        pp     = out_ready && (occ != 0);
        c      = clr;
        e.data = mux_out;
        e.err  = ({garbage_2, mux_out, garbage_1} != fredkin(sel, ip_1, ip_2));
`ifdef MUX21_RECOVER_EN
        e.rec  = fredkin(garbage_2, mux_out, garbage_1);
`else
        e.rec  = 3'b000;
`endif
        @(posedge clk);
        #1;
        if (pp) void'(q.pop_front());
        if (acc) q.push_back(e);
        if (c) begin
            pass_n = 0;
            err_n  = 0;
            flag_m = 1'b0;
        end else if (acc) begin
            if (e.err) begin
                err_n++;
                flag_m = 1'b1;
            end else begin
                pass_n++;
            end
        end
        chk("pass_cnt", pass_cnt, sat(pass_n, 16));
        chk("err_cnt", err_cnt, sat(err_n, 16));
        chk("err_flag", err_flag, flag_m);
        chk("s_pass_cnt", s_pass_cnt, sat(pass_n, 3));
        chk("s_err_cnt", s_err_cnt, sat(err_n, 3));
        chk("s_err_flag", s_err_flag, flag_m);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       sel, ip_1, ip_2;
        logic       mux_out, garbage_1, garbage_2;
        logic       exp_data, exp_err;
        logic [2:0] exp_rec;
    } vec_t;

    vec_t vecs[9];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        //           sel ip1 ip2  mo  g1  g2  data err rec
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b011};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b101};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b110};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b111};
        // faulty: mux_out should be 1; inverse of the observed outputs gives 100
        vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b100};

        rst       = 1'b1;
        clr       = 1'b0;
        out_ready = 1'b0;
        drive_tx(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_out_rec", out_rec, 0);
        chk("rst_err_flag", err_flag, 0);
        chk("rst_pass_cnt", pass_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // Exhaustive legal sweep, one per cycle with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b1;
            sel       = vecs[i].sel;
            ip_1      = vecs[i].ip_1;
            ip_2      = vecs[i].ip_2;
            mux_out   = vecs[i].mux_out;
            garbage_1 = vecs[i].garbage_1;
            garbage_2 = vecs[i].garbage_2;
            cycle();
            chk("vec_data", out_data, vecs[i].exp_data);
            chk("vec_err", out_err, vecs[i].exp_err);
`ifdef MUX21_RECOVER_EN
            chk("vec_rec", out_rec, vecs[i].exp_rec);
`else
            chk("vec_rec_off", out_rec, 0);
`endif
        end
        chk("sweep_pass_cnt", pass_cnt, 8);
        chk("sweep_err_cnt", err_cnt, 0);
        chk("sweep_err_flag", err_flag, 0);

        // Fault injection
        sel = vecs[8].sel; ip_1 = vecs[8].ip_1; ip_2 = vecs[8].ip_2;
        mux_out = vecs[8].mux_out; garbage_1 = vecs[8].garbage_1; garbage_2 = vecs[8].garbage_2;
        cycle();
        chk("fault_data", out_data, vecs[8].exp_data);
        chk("fault_err", out_err, vecs[8].exp_err);
`ifdef MUX21_RECOVER_EN
        chk("fault_rec", out_rec, vecs[8].exp_rec);
`endif
        chk("fault_err_cnt", err_cnt, 1);
        chk("fault_err_flag", err_flag, 1);
        for (int i = 0; i < 10; i++) begin
            drive_legal_random();
            cycle();
            chk("flag_sticky", err_flag, 1);
        end
        in_valid = 1'b0;
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("clr_pass_cnt", pass_cnt, 0);
        chk("clr_err_cnt", err_cnt, 0);
        chk("clr_err_flag", err_flag, 0);

        // clr with a same-cycle failing accept: entry pushed, not counted
        drive_tx(1'b1, 1'b0, 1'b1, 1'b0, 3'b010);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        in_valid = 1'b0;
        chk("clr_acc_flag", err_flag, 0);
        chk("clr_acc_err_cnt", err_cnt, 0);
        chk("clr_acc_pushed_err", out_err, 1);
        cycle();

        // Full and backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_legal_random();
            cycle();
        end
        chk("full_in_ready", in_ready, 0);
        drive_tx(1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("after_pop_in_ready", in_ready, 1);
        cycle();
        chk("refill_in_ready", in_ready, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        chk("drained_out_valid", out_valid, 0);

        // Simultaneous push and pop at occupancy 2
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_legal_random();
            cycle();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_tx(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), (i % 5 == 0) ? 3'b001 : 3'b000);
            cycle();
            chk("stream_out_valid", out_valid, 1);
            chk("stream_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        cycle();
        cycle();
        chk("stream_two_left", out_valid, 0);

        // Saturation on the CNT_W=3 instance
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_legal_random();
            cycle();
        end
        in_valid = 1'b0;
        chk("sat_s_pass_cnt", s_pass_cnt, 7);
        chk("sat_pass_cnt", pass_cnt, 10);
        cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive_tx(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                     ($urandom_range(0, 3) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000);
            out_ready = 1'($urandom_range(0, 2) != 0);
            clr       = 1'($urandom_range(0, 49) == 0);
            cycle();
        end
        clr = 1'b0;

        // Reset mid-stream with 3 entries queued
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_tx(1'b1, 1'b0, 1'b1, 1'b0, 3'b100);
            cycle();
        end
        in_valid = 1'b0;
        chk("pre_rst_out_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_err", out_err, 0);
        chk("mid_rst_pass_cnt", pass_cnt, 0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        chk("mid_rst_err_flag", err_flag, 0);
        chk("mid_rst_s_err_cnt", s_err_cnt, 0);
        q.delete();
        pass_n = 0;
        err_n  = 0;
        flag_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        cycle();
        drive_legal_random();
        cycle();
        in_valid = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
